// File: rtl/key_seq_pkg.sv
// Shared constants and types for the PS/2 key event sequencer: protocol bytes,
// FSM state codes, event payload layout and the Pause sequence table.
package key_seq_pkg;

  localparam int unsigned EV_W      = 10;
  localparam int unsigned PAUSE_LEN = 7;

  localparam logic [7:0] KEY_E0 = 8'hE0;
  localparam logic [7:0] KEY_F0 = 8'hF0;
  localparam logic [7:0] KEY_E1 = 8'hE1;
  localparam logic [7:0] KEY_AA = 8'hAA;
  localparam logic [7:0] KEY_FC = 8'hFC;
  localparam logic [7:0] KEY_FA = 8'hFA;
  localparam logic [7:0] KEY_FE = 8'hFE;
  localparam logic [7:0] KEY_EE = 8'hEE;
  localparam logic [7:0] KEY_00 = 8'h00;
  localparam logic [7:0] KEY_FF = 8'hFF;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_EXT    = 3'd1;
  localparam state_t ST_BRK    = 3'd2;
  localparam state_t ST_EXTBRK = 3'd3;
  localparam state_t ST_PAUSE  = 3'd4;

  // Bytes expected after the leading E1 of the Pause make sequence
  localparam logic [7:0] PAUSE_BYTES [PAUSE_LEN] =
    '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_ev_t;

  typedef struct packed {
    logic       valid;
    logic       ext;
    logic [7:0] code;
  } held_key_t;

endpackage

// File: rtl/key_event_sequencer_if.sv
// Byte-stream input and event valid/ready output of the key event sequencer.
interface key_event_sequencer_if;
  import key_seq_pkg::*;

  logic [7:0]      CODE;
  logic            NEW_CODE;
  logic [EV_W-1:0] EV_DATA;
  logic            EV_VALID;
  logic            EV_READY;

  modport master (output CODE, NEW_CODE, EV_READY, input EV_DATA, EV_VALID);
  modport slave  (input CODE, NEW_CODE, EV_READY, output EV_DATA, EV_VALID);
endinterface

// File: rtl/key_event_fifo.sv
// Synchronous event FIFO with a registered head word; a push into an empty
// FIFO becomes visible on the output only after the write edge.
module key_event_fifo
  import key_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            push,
  input  logic [EV_W-1:0] push_data,
  input  logic            pop,
  output logic [EV_W-1:0] dout,
  output logic            valid,
  output logic            full
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [EV_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [EV_W-1:0] head_d;
  logic            do_push, do_pop;

  // A full FIFO still accepts a push when the head leaves on the same edge
  always_comb begin
    do_pop  = pop & valid;
    do_push = push & (~full | do_pop);
    count_d = count_q;
    if (do_push & ~do_pop)
      count_d = count_q + CW'(1);
    else if (~do_push & do_pop)
      count_d = count_q - CW'(1);

    head_d = dout;
    if (do_pop) begin
      if (count_q > CW'(1))
        head_d = mem[rd_ptr_q + AW'(1)];
      else if (do_push)
        head_d = push_data;
    end else if (do_push && count_q == '0) begin
      head_d = push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout     <= '0;
      valid    <= 1'b0;
      full     <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      dout    <= head_d;
      valid   <= (count_d != '0);
      full    <= (count_d == CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/key_event_sequencer.sv
// PS/2 multi-byte scan-code sequencer feeding a small event FIFO.
// Optional KEYSEQ_TYPEMATIC_FILTER_EN suppresses auto-repeated make events.
module key_event_sequencer
  import key_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  CLK,
  input  logic                  RST,
  key_event_sequencer_if.slave  bus,
  input  logic                  CLR,
  output logic                  OVERFLOW,
  output logic                  SEQ_ERR,
  output logic                  BAT_OK
);
  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned PIDX_W = 3;

  state_t            state_q, state_d;
  logic [PIDX_W-1:0] pidx_q, pidx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              seq_err_d, bat_ok_d, ovr_byte;
  logic              emit, emit_f, pop, drop;
  key_ev_t           ev;
  logic [EV_W-1:0]   fifo_dout;
  logic              fifo_valid, fifo_full;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      pidx_q   <= '0;
      tmo_q    <= '0;
      SEQ_ERR  <= 1'b0;
      BAT_OK   <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      state_q  <= state_d;
      pidx_q   <= pidx_d;
      tmo_q    <= tmo_d;
      SEQ_ERR  <= seq_err_d;
      BAT_OK   <= bat_ok_d;
      OVERFLOW <= (OVERFLOW & ~CLR) | ovr_byte | drop;
    end
  end

  // Byte-driven sequencing; the idle timeout only acts on cycles without a byte
  always_comb begin
    state_d   = state_q;
    pidx_d    = pidx_q;
    seq_err_d = 1'b0;
    bat_ok_d  = BAT_OK;
    ovr_byte  = 1'b0;
    emit      = 1'b0;
    ev        = '0;
    tmo_d     = (bus.NEW_CODE || state_q == ST_IDLE) ? '0 : tmo_q + TMO_W'(1);

    if (bus.NEW_CODE) begin
      unique case (state_q)
        ST_IDLE: begin
          case (bus.CODE)
            KEY_E0:                 state_d = ST_EXT;
            KEY_F0:                 state_d = ST_BRK;
            KEY_E1: begin           state_d = ST_PAUSE; pidx_d = '0; end
            KEY_AA:                 bat_ok_d = 1'b1;
            KEY_FC:                 bat_ok_d = 1'b0;
            KEY_00, KEY_FF:         ovr_byte = 1'b1;
            KEY_FA, KEY_FE, KEY_EE: begin end
            default: begin
              emit = 1'b1;
              ev   = {1'b0, 1'b0, bus.CODE};
            end
          endcase
        end
        ST_EXT: begin
          case (bus.CODE)
            KEY_F0: state_d = ST_EXTBRK;
            KEY_E0: state_d = ST_EXT;
            KEY_E1: begin seq_err_d = 1'b1; state_d = ST_IDLE; end
            default: begin
              emit    = 1'b1;
              ev      = {1'b1, 1'b0, bus.CODE};
              state_d = ST_IDLE;
            end
          endcase
        end
        ST_BRK, ST_EXTBRK: begin
          state_d = ST_IDLE;
          if (bus.CODE inside {KEY_E0, KEY_F0, KEY_E1}) begin
            seq_err_d = 1'b1;
          end else begin
            emit = 1'b1;
            ev   = {state_q == ST_EXTBRK, 1'b1, bus.CODE};
          end
        end
        ST_PAUSE: begin
          if (bus.CODE == PAUSE_BYTES[pidx_q]) begin
            if (pidx_q == PIDX_W'(PAUSE_LEN - 1)) begin
              emit    = 1'b1;
              ev      = {1'b1, 1'b0, KEY_E1};
              state_d = ST_IDLE;
            end else begin
              pidx_d = pidx_q + PIDX_W'(1);
            end
          end else begin
            seq_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      seq_err_d = 1'b1;
      state_d   = ST_IDLE;
    end
  end

`ifdef KEYSEQ_TYPEMATIC_FILTER_EN
  held_key_t held_q, held_d;
  logic      held_match;

  // Pause is the only {ext,make,E1} event and bypasses the held-key logic
  always_comb begin
    held_d     = held_q;
    emit_f     = emit;
    held_match = held_q.valid && (held_q.ext == ev.ext) && (held_q.code == ev.code);
    if (emit && !(ev.ext && !ev.brk && ev.code == KEY_E1)) begin
      if (!ev.brk) begin
        if (held_match) emit_f = 1'b0;
        else            held_d = '{valid: 1'b1, ext: ev.ext, code: ev.code};
      end else if (held_match) begin
        held_d.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) held_q <= '0;
    else     held_q <= held_d;
  end
`else
  always_comb emit_f = emit;
`endif

  assign pop  = fifo_valid & bus.EV_READY;
  assign drop = emit_f & fifo_full & ~pop;

  key_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (emit_f),
    .push_data (ev),
    .pop       (bus.EV_READY),
    .dout      (fifo_dout),
    .valid     (fifo_valid),
    .full      (fifo_full)
  );

  assign bus.EV_DATA  = fifo_dout;
  assign bus.EV_VALID = fifo_valid;

endmodule

// File: doc/key_event_sequencer.md
# key_event_sequencer

Controller behind the PS/2 scan-code receiver. Consumes the receiver's byte stream (`CODE`/`NEW_CODE`) and sequences the multi-byte protocol: E0 extended prefix, F0 break prefix, the 8-byte E1 Pause sequence, and keyboard status bytes. Emits one decoded key event per completed sequence into a small FIFO, read by the application over a valid/ready handshake.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 100000: idle `CLK` cycles allowed mid-sequence before abort (2 ms at 50 MHz).
- `CLK` in 1: system clock; the only clock.
- `RST` in 1: synchronous, active-high reset.
- `CODE` in 8: byte from the receiver; valid when `NEW_CODE` is high.
- `NEW_CODE` in 1: single-cycle strobe, one per received byte.
- `EV_DATA` out 10: `{ext, brk, code[7:0]}`; bit 9 = extended, bit 8 = break.
- `EV_VALID` out 1: FIFO non-empty.
- `EV_READY` in 1: consumer pop; the head is popped on a cycle with `EV_VALID & EV_READY`.
- `CLR` in 1: clears `OVERFLOW`.
- `OVERFLOW` out 1: sticky; set on an event dropped because the FIFO is full, or on a keyboard overrun byte (00/FF).
- `SEQ_ERR` out 1: one-cycle pulse on a malformed or timed-out sequence.
- `BAT_OK` out 1: set by AA, cleared by FC.

## Operation
- Reset values: state IDLE, FIFO empty, `EV_VALID`=0, `EV_DATA`=0, `OVERFLOW`=0, `SEQ_ERR`=0, `BAT_OK`=0, timeout counter 0.
- States: IDLE, EXT (after E0), BRK (after F0), EXTBRK (after E0 F0), PAUSE (after E1).
- Transitions, evaluated only on cycles with `NEW_CODE`=1.
- IDLE:
  - E0→EXT; F0→BRK; E1→PAUSE with index 0.
  - AA sets `BAT_OK`; FC clears `BAT_OK`.
  - 00/FF set `OVERFLOW`.
  - FA/FE/EE are discarded.
  - Any other byte emits `{0,0,code}` and stays in IDLE.
- EXT:
  - F0→EXTBRK; E0 stays in EXT.
  - E1 pulses `SEQ_ERR` and goes to IDLE.
  - Any other byte emits `{1,0,code}` and goes to IDLE.
- BRK: E0, F0 or E1 pulses `SEQ_ERR` and goes to IDLE; any other byte emits `{0,1,code}` and goes to IDLE.
- EXTBRK: E0, F0 or E1 pulses `SEQ_ERR` and goes to IDLE; any other byte emits `{1,1,code}` and goes to IDLE.
- PAUSE:
  - Bytes must match 14 77 E1 F0 14 F0 77 in order.
  - A mismatch pulses `SEQ_ERR` and goes to IDLE.
  - After the 7th byte, emits `{1,0,8'hE1}` and goes to IDLE.
- Timeout:
  - The counter clears on every `NEW_CODE` and in IDLE; it increments otherwise.
  - On reaching `TIMEOUT_CYCLES-1` in a non-IDLE state: `SEQ_ERR` pulse, go to IDLE, no event.
- FIFO:
  - Emit with FIFO full and no pop that cycle: the event is dropped and `OVERFLOW` is set.
  - Push and pop on the same cycle while full: both succeed, no overflow.
  - Push while empty: the event is not bypassed to the output.
- `CLR` clears `OVERFLOW`. If `CLR` and a new overflow occur on the same cycle, `OVERFLOW` stays set.

## Timing
- Byte accepted at edge N (`NEW_CODE`=1): state updates at edge N; an event is written into the FIFO at edge N.
- `EV_VALID`/`EV_DATA` are valid after edge N. `EV_DATA` is registered FIFO head data.
- Latency from the final byte strobe to `EV_VALID`: 1 cycle.
- `SEQ_ERR` is high for exactly the cycle after the offending edge.
- `EV_DATA` is held stable while `EV_VALID=1` and `EV_READY=0`.
- `RST` takes priority over everything.
  - A `NEW_CODE` on a reset cycle is ignored.
  - Reset mid-sequence returns to IDLE with no `SEQ_ERR`.

## Configuration
- `KEYSEQ_TYPEMATIC_FILTER_EN` defined: adds a held-key register `{valid, ext, code}`.
  - A make event equal to the held key is discarded (suppresses auto-repeat).
  - A make with a different key is emitted and replaces the held key.
  - A break matching the held key clears `valid`.
  - The Pause event is never filtered.
- Undefined: every make is emitted; no held-key register exists.

## Structure
- Package `key_seq_pkg` holds:
  - byte constants E0, F0, E1, AA, FC, FA, FE, EE, 00, FF;
  - the state enum;
  - `EV_W`=10;
  - the 7-entry Pause expected-byte table.
- Sub-module `key_event_fifo`: synchronous FIFO, `FIFO_DEPTH`×`EV_W`, with valid/ready output and a full flag.
- Top level holds the FSM, the timeout counter, the status flags and the optional filter.

## Test plan
- Bytes 1C, then F0 1C, then E0 75, then E0 F0 75 -> events 01C, 11C, 275, 375, in order, each 1 cycle after its last strobe.
- E1 14 77 E1 F0 14 F0 77 -> one event 2E1; sequence E1 14 00 -> `SEQ_ERR` pulse, no event.
- E0, then no byte for 100000 cycles -> `SEQ_ERR` pulse; next byte 1C -> event 01C.
- `EV_READY`=0, 9 single-byte codes with `FIFO_DEPTH`=8 -> 8 events stored, `OVERFLOW`=1; `CLR` -> 0; drain order matches input.
- AA -> `BAT_OK`=1; FC -> 0; FF -> `OVERFLOW`=1; FA -> no event.
- With `KEYSEQ_TYPEMATIC_FILTER_EN`: 1C 1C 1C F0 1C 1C -> events 01C, 11C, 01C. Without the macro -> 01C ×3, 11C, 01C.
